arf_mp: RTL and testbench
=========================

Name: arf_mp

Overview:
Parametrised multi-port architectural register file holding the committed integer state. The ROB writes it at retirement; issue/operand-fetch and the difftest/debug path read it. It adds the following:
- configurable register count and port counts
- explicit same-cycle WAW resolution
- optional commit-to-read bypass
- a sequenced post-reset clear FSM in place of a full-array async reset
- a registered debug read port
- a retired-write counter

Parameters:
XLEN, Cfg.XLEN, data width in bits.
NREG, 32, number of architectural registers; power of two, at least 2; entry 0 hardwired to zero.
NUM_WR, Cfg.NRET, commit write ports.
NUM_RD, 8, operand read ports.
BYPASS, 1, 1 = read data reflects same-cycle commit writes; 0 = reads see array contents only.
AW, $clog2(NREG), register address width (derived).

Ports:
clk_i  in  1  clock.
rst_i  in  1  asynchronous, active-high reset.
init_req_i  in  1  single-cycle pulse that restarts the clear sweep while in RUN.
ready_o  out  1  high when in RUN; array contents are valid.
we_i  in  NUM_WR  per-port commit write enable.
waddr_i  in  NUM_WR x AW  commit write address.
wdata_i  in  NUM_WR x XLEN  commit write data.
raddr_i  in  NUM_RD x AW  operand read address.
rdata_o  out  NUM_RD x XLEN  operand read data (combinational).
dbg_raddr_i  in  AW  debug read address.
dbg_rdata_o  out  XLEN  debug read data, registered with 1-cycle latency.
wr_cnt_o  out  64  count of committed register writes with non-zero address.

Behaviour:
Reset (rst_i high, asynchronous):
- FSM goes to INIT, sweep index goes to 1.
- ready_o=0, dbg_rdata_o=0, wr_cnt_o=0.
- The array itself is not reset.

States:
- INIT:
  - Each cycle writes 0 to entry[sweep_idx], then sweep_idx increments.
  - When the entry at sweep_idx==NREG-1 has been cleared, the FSM goes to RUN.
  - INIT lasts NREG-1 cycles after reset deassertion; ready_o rises on the next cycle.
- RUN: normal operation. init_req_i=1 moves the FSM to INIT with sweep_idx=1 on the next edge.

Behaviour in INIT:
- we_i is ignored; a write attempt is an assertion error.
- rdata_o and dbg_rdata_o are 0.
- wr_cnt_o is frozen.

Commit writes (RUN only):
- A port with we_i[k]=1 and waddr_i[k]!=0 writes at the clock edge.
- WAW: if several ports target the same address in one cycle, the highest-index port wins (port k is younger than port k-1).
- Writes to address 0 are dropped.
- If init_req_i and we_i arrive in the same cycle, init takes priority and all writes that cycle are dropped.

Reads:
- raddr_i==0 returns 0 regardless of BYPASS.
- With BYPASS=1 and a matching enabled write this cycle, the read returns the wdata_i of the highest-index matching port.
- Otherwise the read returns the array contents.

Debug port:
- dbg_rdata_o <= array[dbg_raddr_i] on each edge in RUN; address 0 gives 0.
- No bypass on this port.
- Writes in the same cycle are visible one cycle later.

wr_cnt_o:
- Adds the popcount of (we_i[k] && waddr_i[k]!=0) each RUN cycle; duplicate-address writes each count.
- Wraps modulo 2^64.
- Not cleared by init_req_i; cleared only by rst_i.

Mid-sweep rst_i: the sweep restarts from index 1.

All outputs are deterministic for X-free inputs. No latches. Only the array uses non-reset flops.

Test Plan:
- Reset, NREG=32: release rst_i -> ready_o=0 for 31 cycles, then 1. dbg reads of every address in RUN return 0.
- RUN, NUM_WR=4: write port0 x5=0x11 and port2 x5=0x22 in the same cycle -> next cycle rdata_o for raddr=5 is 0x22. wr_cnt_o increments by 2.
- BYPASS=1: write x7=0xDEAD while raddr_i[3]=7 -> rdata_o[3]=0xDEAD in the same cycle. With BYPASS=0 the same read shows the old value 0, then 0xDEAD on the next cycle.
- Write x0=0xFFFF on port1 with raddr_i[0]=0 -> rdata_o[0]=0 both in the same cycle and later. wr_cnt_o is unchanged.
- In RUN with x3=0x33, assert init_req_i together with a write x3=0x44:
  - the write is dropped;
  - ready_o=0 for 31 cycles;
  - afterwards x3 reads 0;
  - wr_cnt_o keeps its prior value.
- Assert rst_i at sweep index 10, then release -> full 31-cycle sweep again; wr_cnt_o=0. dbg_raddr_i=9 set at cycle t shows 0 on dbg_rdata_o at t+1 once in RUN.

Source files
------------

// File: rtl/arf_mp.sv
// arf_mp: multi-port architectural register file with post-reset clear sweep, commit bypass and debug port
module arf_mp #(
  parameter int XLEN   = 64,
  parameter int NREG   = 32,
  parameter int NUM_WR = 4,
  parameter int NUM_RD = 8,
  parameter int BYPASS = 1,
  localparam int AW    = $clog2(NREG)
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic                           init_req_i,
  output logic                           ready_o,
  input  logic [NUM_WR-1:0]              we_i,
  input  logic [NUM_WR-1:0][AW-1:0]      waddr_i,
  input  logic [NUM_WR-1:0][XLEN-1:0]    wdata_i,
  input  logic [NUM_RD-1:0][AW-1:0]      raddr_i,
  output logic [NUM_RD-1:0][XLEN-1:0]    rdata_o,
  input  logic [AW-1:0]                  dbg_raddr_i,
  output logic [XLEN-1:0]                dbg_rdata_o,
  output logic [63:0]                    wr_cnt_o
);
  typedef enum logic {INIT, RUN} state_t;
  state_t state, state_n;
  logic [AW-1:0] sweep, sweep_n;
  logic [XLEN-1:0] mem [NREG];
  logic [NUM_WR-1:0] wen;
  logic [63:0] inc;
  logic run;
  assign run = (state == RUN);
  assign ready_o = run;
  always_comb begin
    state_n = state;
    sweep_n = sweep;
    if (!run) begin
      sweep_n = sweep + AW'(1);
      state_n = (sweep == AW'(NREG - 1)) ? RUN : INIT;
    end else if (init_req_i) begin
      state_n = INIT;
      sweep_n = AW'(1);
    end
  end
  // A pending init request squashes every commit in its cycle, including bypass and counting.
  always_comb begin
    wen = '0;
    inc = '0;
    for (int k = 0; k < NUM_WR; k++) begin
      wen[k] = run && !init_req_i && we_i[k] && (waddr_i[k] != '0);
      inc = inc + 64'(wen[k]);
    end
  end
  always_comb begin
    for (int r = 0; r < NUM_RD; r++) begin
      rdata_o[r] = '0;
      if (run && raddr_i[r] != '0) begin
        rdata_o[r] = mem[raddr_i[r]];
        for (int k = 0; k < NUM_WR; k++)
          if (BYPASS != 0 && wen[k] && waddr_i[k] == raddr_i[r]) rdata_o[r] = wdata_i[k];
      end
    end
  end
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state       <= INIT;
      sweep       <= AW'(1);
      wr_cnt_o    <= '0;
      dbg_rdata_o <= '0;
    end else begin
      state       <= state_n;
      sweep       <= sweep_n;
      wr_cnt_o    <= wr_cnt_o + inc;
      dbg_rdata_o <= (run && !init_req_i && dbg_raddr_i != '0) ? mem[dbg_raddr_i] : '0;
    end
  end
  // Ascending port order lets the youngest port win same-address collisions.
  always_ff @(posedge clk_i) begin
    if (!run) mem[sweep] <= '0;
    else
      for (int k = 0; k < NUM_WR; k++)
        if (wen[k]) mem[waddr_i[k]] <= wdata_i[k];
  end
  a_no_write_in_init: assert property (@(posedge clk_i) disable iff (rst_i) !run |-> we_i == '0);
endmodule

// File: tb/tb_arf_mp.sv
// tb_arf_mp: randomized and directed checks of arf_mp against a behavioural register-file model
module tb_arf_mp;
  localparam int XLEN = 64, NREG = 32, NW = 4, NR = 8, AW = 5;
  logic clk = 0, rst = 1, init_req = 0;
  logic [NW-1:0] we = '0;
  logic [NW-1:0][AW-1:0] waddr = '0;
  logic [NW-1:0][XLEN-1:0] wdata = '0;
  logic [NR-1:0][AW-1:0] raddr = '0;
  logic [AW-1:0] dbg_raddr = '0;
  logic ready, ready_nb;
  logic [NR-1:0][XLEN-1:0] rdata, rdata_nb;
  logic [XLEN-1:0] dbg, dbg_nb;
  logic [63:0] cnt, cnt_nb;
  logic [XLEN-1:0] model [NREG];
  logic [63:0] mcnt = '0;
  int vecs = 0, errs = 0;

  always #5 clk = ~clk;

  arf_mp #(.XLEN(XLEN), .NREG(NREG), .NUM_WR(NW), .NUM_RD(NR), .BYPASS(1)) u_dut (
    .clk_i(clk), .rst_i(rst), .init_req_i(init_req), .ready_o(ready),
    .we_i(we), .waddr_i(waddr), .wdata_i(wdata), .raddr_i(raddr), .rdata_o(rdata),
    .dbg_raddr_i(dbg_raddr), .dbg_rdata_o(dbg), .wr_cnt_o(cnt));

  arf_mp #(.XLEN(XLEN), .NREG(NREG), .NUM_WR(NW), .NUM_RD(NR), .BYPASS(0)) u_nb (
    .clk_i(clk), .rst_i(rst), .init_req_i(init_req), .ready_o(ready_nb),
    .we_i(we), .waddr_i(waddr), .wdata_i(wdata), .raddr_i(raddr), .rdata_o(rdata_nb),
    .dbg_raddr_i(dbg_raddr), .dbg_rdata_o(dbg_nb), .wr_cnt_o(cnt_nb));

  function automatic logic [XLEN-1:0] exp_rd(input logic [AW-1:0] a, input bit byp);
    logic [XLEN-1:0] v;
    if (a == 0) return '0;
    v = model[a];
    if (byp) for (int k = 0; k < NW; k++) if (we[k] && waddr[k] == a) v = wdata[k];
    return v;
  endfunction

  task automatic commit();
    for (int k = 0; k < NW; k++)
      if (we[k] && waddr[k] != 0) begin
        model[waddr[k]] = wdata[k];
        mcnt = mcnt + 1;
      end
  endtask

  task automatic clear_model();
    for (int i = 0; i < NREG; i++) model[i] = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1;
    repeat (2) @(posedge clk);
    #1 rst = 0;
    clear_model();
    mcnt = 0;
    for (int i = 0; i < NREG - 1; i++) begin
      vecs++;
      if (ready !== 1'b0) begin errs++; $display("FAIL reset_ready_low cyc %0d: got %b want 0", i, ready); end
      tick();
    end
    vecs++;
    if (ready !== 1'b1) begin errs++; $display("FAIL reset_ready_high: got %b want 1", ready); end
    vecs++;
    if (cnt !== 64'd0) begin errs++; $display("FAIL reset_cnt: got %0d want 0", cnt); end
    for (int a = 0; a < NREG; a++) begin
      dbg_raddr = AW'(a);
      tick();
      vecs++;
      if (dbg !== '0) begin errs++; $display("FAIL reset_dbg x%0d: got %h want 0", a, dbg); end
    end
  endtask

  task automatic test_waw();
    logic [63:0] c0;
    c0 = cnt;
    we = 4'b0101;
    waddr[0] = 5; wdata[0] = 64'h11;
    waddr[2] = 5; wdata[2] = 64'h22;
    raddr[0] = 5;
    #1;
    vecs++;
    if (rdata[0] !== 64'h22) begin errs++; $display("FAIL waw_bypass: got %h want 22", rdata[0]); end
    commit();
    tick();
    we = '0;
    #1;
    vecs++;
    if (rdata[0] !== 64'h22) begin errs++; $display("FAIL waw_array: got %h want 22", rdata[0]); end
    vecs++;
    if (cnt !== c0 + 2) begin errs++; $display("FAIL waw_cnt: got %0d want %0d", cnt, c0 + 2); end
    tick();
  endtask

  task automatic test_bypass();
    we = 4'b0001;
    waddr[0] = 7; wdata[0] = 64'hDEAD;
    raddr[3] = 7;
    #1;
    vecs++;
    if (rdata[3] !== 64'hDEAD) begin errs++; $display("FAIL bypass_on: got %h want dead", rdata[3]); end
    vecs++;
    if (rdata_nb[3] !== 64'h0) begin errs++; $display("FAIL bypass_off_same: got %h want 0", rdata_nb[3]); end
    commit();
    tick();
    we = '0;
    #1;
    vecs++;
    if (rdata_nb[3] !== 64'hDEAD) begin errs++; $display("FAIL bypass_off_next: got %h want dead", rdata_nb[3]); end
    tick();
  endtask

  task automatic test_x0();
    logic [63:0] c0;
    c0 = cnt;
    we = 4'b0010;
    waddr[1] = 0; wdata[1] = 64'hFFFF;
    raddr[0] = 0;
    #1;
    vecs++;
    if (rdata[0] !== '0) begin errs++; $display("FAIL x0_same: got %h want 0", rdata[0]); end
    commit();
    tick();
    we = '0;
    #1;
    vecs++;
    if (rdata[0] !== '0) begin errs++; $display("FAIL x0_later: got %h want 0", rdata[0]); end
    vecs++;
    if (cnt !== c0) begin errs++; $display("FAIL x0_cnt: got %0d want %0d", cnt, c0); end
    tick();
  endtask

  task automatic test_random();
    logic [XLEN-1:0] ed;
    for (int i = 0; i < 300; i++) begin
      for (int k = 0; k < NW; k++) begin
        we[k] = 1'($urandom_range(0, 1));
        waddr[k] = $urandom_range(0, 1) ? AW'($urandom_range(0, 3)) : AW'($urandom);
        wdata[k] = {$urandom, $urandom};
      end
      for (int r = 0; r < NR; r++) raddr[r] = $urandom_range(0, 1) ? AW'($urandom_range(0, 3)) : AW'($urandom);
      dbg_raddr = AW'($urandom);
      #1;
      for (int r = 0; r < NR; r++) begin
        vecs++;
        if (rdata[r] !== exp_rd(raddr[r], 1))
          begin errs++; $display("FAIL rand_rd byp it%0d p%0d: got %h want %h", i, r, rdata[r], exp_rd(raddr[r], 1)); end
        vecs++;
        if (rdata_nb[r] !== exp_rd(raddr[r], 0))
          begin errs++; $display("FAIL rand_rd nobyp it%0d p%0d: got %h want %h", i, r, rdata_nb[r], exp_rd(raddr[r], 0)); end
      end
      ed = exp_rd(dbg_raddr, 0);
      commit();
      tick();
      vecs++;
      if (dbg !== ed) begin errs++; $display("FAIL rand_dbg it%0d: got %h want %h", i, dbg, ed); end
      vecs++;
      if (cnt !== mcnt) begin errs++; $display("FAIL rand_cnt it%0d: got %0d want %0d", i, cnt, mcnt); end
    end
    we = '0;
  endtask

  task automatic test_init_req();
    we = 4'b0001; waddr[0] = 3; wdata[0] = 64'h33;
    commit();
    tick();
    we = '0;
    raddr[0] = 3;
    #1;
    vecs++;
    if (rdata[0] !== 64'h33) begin errs++; $display("FAIL init_pre: got %h want 33", rdata[0]); end
    tick();
    init_req = 1;
    we = 4'b0001; waddr[0] = 3; wdata[0] = 64'h44;
    tick();
    init_req = 0;
    we = '0;
    clear_model();
    for (int i = 0; i < NREG - 1; i++) begin
      vecs++;
      if (ready !== 1'b0 || rdata[0] !== '0)
        begin errs++; $display("FAIL init_sweep cyc %0d: got ready %b data %h want 0 0", i, ready, rdata[0]); end
      tick();
    end
    vecs++;
    if (ready !== 1'b1) begin errs++; $display("FAIL init_ready: got %b want 1", ready); end
    vecs++;
    if (rdata[0] !== '0) begin errs++; $display("FAIL init_x3: got %h want 0", rdata[0]); end
    vecs++;
    if (cnt !== mcnt) begin errs++; $display("FAIL init_cnt: got %0d want %0d", cnt, mcnt); end
  endtask

  task automatic test_mid_reset();
    init_req = 1;
    tick();
    init_req = 0;
    repeat (9) tick();
    rst = 1;
    #2 rst = 0;
    clear_model();
    mcnt = 0;
    for (int i = 0; i < NREG - 1; i++) begin
      vecs++;
      if (ready !== 1'b0) begin errs++; $display("FAIL midrst_ready_low cyc %0d: got %b want 0", i, ready); end
      @(posedge clk);
      #1;
    end
    vecs++;
    if (ready !== 1'b1) begin errs++; $display("FAIL midrst_ready_high: got %b want 1", ready); end
    vecs++;
    if (cnt !== 64'd0) begin errs++; $display("FAIL midrst_cnt: got %0d want 0", cnt); end
    dbg_raddr = 9;
    tick();
    vecs++;
    if (dbg !== '0) begin errs++; $display("FAIL midrst_dbg: got %h want 0", dbg); end
  endtask

  initial begin
    test_reset();
    test_waw();
    test_bypass();
    test_x0();
    test_random();
    test_init_req();
    test_random();
    test_mid_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
